fft_sdf_stage: RTL and testbench

Vectorised radix-2 single-path delay-feedback (SDF) butterfly stage for the FFT pipeline. It accepts frames of 2·DEPTH complex vectors, each ARRAY lanes wide. It pairs element n with element n+DEPTH through an internal enable-gated delay line, then emits DEPTH sum vectors followed by DEPTH difference vectors. It sits directly downstream of the input sample buffer and feeds the next twiddle/butterfly stage.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_delay_en.sv | 38 +++
 rtl/fft_sdf_stage.sv | 146 ++++++++++++++
 tb/tb_fft_sdf_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the SDF FFT butterfly stages: control states and default sample/vector shapes.
package fft_pkg;

   localparam int DATA_DEF  = 9;
   localparam int ARRAY_DEF = 16;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   typedef logic signed [DATA_DEF-1:0]        sample_t;
   typedef logic signed [DATA_DEF:0]          wsample_t;
   typedef logic [ARRAY_DEF*DATA_DEF-1:0]     vec_t;
   typedef logic [ARRAY_DEF*(DATA_DEF+1)-1:0] wvec_t;

endpackage

// File: rtl/fft_delay_en.sv
// Enable-gated complex delay line: DEPTH stages of ARRAY lanes, W bits per component.
module fft_delay_en #(
   parameter int W     = 10,
   parameter int ARRAY = 16,
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 shift_en,
   input  logic [ARRAY*W-1:0]   din_re,
   input  logic [ARRAY*W-1:0]   din_im,
   output logic [ARRAY*W-1:0]   dout_re,
   output logic [ARRAY*W-1:0]   dout_im
);

   logic [ARRAY*W-1:0] sr_re [DEPTH];
   logic [ARRAY*W-1:0] sr_im [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_re[i] <= '0;
            sr_im[i] <= '0;
         end
      end else if (shift_en) begin
         sr_re[0] <= din_re;
         sr_im[0] <= din_im;
         for (int i = 1; i < DEPTH; i++) begin
            sr_re[i] <= sr_re[i-1];
            sr_im[i] <= sr_im[i-1];
         end
      end
   end

   assign dout_re = sr_re[DEPTH-1];
   assign dout_im = sr_im[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage, ARRAY lanes per vector.
//
// state   | meaning
// FILL    | first half of frame: load delay line, emit previous frame's diffs if pend
// COMPUTE | second half: emit a+b, feed a-b back into the delay line
// DRAIN   | source went idle after a frame: flush held diffs, input blocked
module fft_sdf_stage
   import fft_pkg::*;
#(
   parameter int DATA  = DATA_DEF,
   parameter int ARRAY = ARRAY_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ARRAY*DATA-1:0]     in_re,
   input  logic [ARRAY*DATA-1:0]     in_im,
   output logic                      out_valid,
   output logic [ARRAY*(DATA+1)-1:0] out_re,
   output logic [ARRAY*(DATA+1)-1:0] out_im
);

   localparam int W  = DATA + 1;
   localparam int VW = ARRAY * W;
   localparam int CW = $clog2(2 * DEPTH);
   localparam int DW = $clog2(DEPTH);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [DW-1:0]   dcnt, dcnt_n;
   logic            pend, pend_n;
   logic            accept, shift_en, res_v;
   logic [VW-1:0]   ext_re, ext_im, sum_re, sum_im, dif_re, dif_im;
   logic [VW-1:0]   dly_re, dly_im, din_re, din_im, res_re, res_im;

   assign in_ready = (state != DRAIN);
   assign accept   = in_valid && in_ready;

   for (genvar l = 0; l < ARRAY; l++) begin : g_lane
      assign ext_re[l*W +: W] = {in_re[l*DATA+DATA-1], in_re[l*DATA +: DATA]};
      assign ext_im[l*W +: W] = {in_im[l*DATA+DATA-1], in_im[l*DATA +: DATA]};
      assign sum_re[l*W +: W] = dly_re[l*W +: W] + ext_re[l*W +: W];
      assign sum_im[l*W +: W] = dly_im[l*W +: W] + ext_im[l*W +: W];
      assign dif_re[l*W +: W] = dly_re[l*W +: W] - ext_re[l*W +: W];
      assign dif_im[l*W +: W] = dly_im[l*W +: W] - ext_im[l*W +: W];
   end

   fft_delay_en #(.W(W), .ARRAY(ARRAY), .DEPTH(DEPTH)) u_dly (
      .clk      (clk),
      .rstn     (rstn),
      .shift_en (shift_en),
      .din_re   (din_re),
      .din_im   (din_im),
      .dout_re  (dly_re),
      .dout_im  (dly_im)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FILL;
         cnt   <= '0;
         dcnt  <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dcnt  <= dcnt_n;
         pend  <= pend_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      dcnt_n   = dcnt;
      pend_n   = pend;
      shift_en = 1'b0;
      din_re   = ext_re;
      din_im   = ext_im;
      res_v    = 1'b0;
      res_re   = dly_re;
      res_im   = dly_im;
      case (state)
         FILL: begin
            if (accept) begin
               shift_en = 1'b1;
               res_v    = pend;
               cnt_n    = cnt + CW'(1);
               if (cnt == CW'(DEPTH - 1)) begin
                  state_n = COMPUTE;
                  pend_n  = 1'b0;
               end
            end else if (cnt == '0 && pend) begin
               // idle right at a frame boundary: nothing will push the diffs out
               state_n = DRAIN;
               dcnt_n  = '0;
            end
         end
         COMPUTE: begin
            if (accept) begin
               shift_en = 1'b1;
               din_re   = dif_re;
               din_im   = dif_im;
               res_v    = 1'b1;
               res_re   = sum_re;
               res_im   = sum_im;
               cnt_n    = cnt + CW'(1);
               if (cnt == CW'(2 * DEPTH - 1)) begin
                  state_n = FILL;
                  pend_n  = 1'b1;
               end
            end
         end
         DRAIN: begin
            shift_en = 1'b1;
            din_re   = '0;
            din_im   = '0;
            res_v    = 1'b1;
            dcnt_n   = dcnt + DW'(1);
            if (dcnt == DW'(DEPTH - 1)) begin
               state_n = FILL;
               pend_n  = 1'b0;
               dcnt_n  = '0;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         out_valid <= res_v;
         if (res_v) begin
            out_re <= res_re;
            out_im <= res_im;
         end
      end
   end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage: frame ordering, drain, overlap, stalls, extremes, resets.
module tb_fft_sdf_stage;

   localparam int DATA  = 9;
   localparam int ARRAY = 16;
   localparam int DEPTH = 16;
   localparam int W     = DATA + 1;
   localparam int VI    = ARRAY * DATA;
   localparam int VO    = ARRAY * W;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic [VI-1:0] in_re = '0;
   logic [VI-1:0] in_im = '0;
   logic          in_ready;
   logic          out_valid;
   logic [VO-1:0] out_re;
   logic [VO-1:0] out_im;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_waits = 0;
   logic [VO-1:0] q_re[$];
   logic [VO-1:0] q_im[$];
   int            q_t[$];

   always #5 clk = ~clk;

   fft_sdf_stage #(.DATA(DATA), .ARRAY(ARRAY), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im)
   );

   always @(negedge clk) begin
      cyc++;
      if (out_valid) begin
         q_re.push_back(out_re);
         q_im.push_back(out_im);
         q_t.push_back(cyc);
      end
   end

   function automatic logic [VI-1:0] rep_i(input int v);
      logic [VI-1:0] r;
      for (int l = 0; l < ARRAY; l++) r[l*DATA +: DATA] = DATA'(v);
      return r;
   endfunction

   function automatic logic [VO-1:0] rep_o(input int v);
      logic [VO-1:0] r;
      for (int l = 0; l < ARRAY; l++) r[l*W +: W] = W'(v);
      return r;
   endfunction

   // two-frame stream: frame0 (n, -n) then frame1 (2n, n), drained at the end
   function automatic int exp2_re(input int i);
      if (i < 16) return 2*i + 16;
      if (i < 32) return -16;
      if (i < 48) return 4*(i-32) + 32;
      return -32;
   endfunction

   function automatic int exp2_im(input int i);
      if (i < 16) return -(2*i + 16);
      if (i < 32) return 16;
      if (i < 48) return 2*(i-32) + 16;
      return -16;
   endfunction

   task automatic clear_q();
      q_re.delete();
      q_im.delete();
      q_t.delete();
   endtask

   task automatic push(input logic [VI-1:0] re, input logic [VI-1:0] im);
      int g;
      g = 0;
      in_re = re;
      in_im = im;
      in_valid = 1'b1;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      ready_waits += g;
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      in_valid = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      clear_q();
   endtask

   task automatic test_reset();
      int low;
      apply_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_re !== '0) begin errors++; $display("FAIL rst_out_re got=%h exp=0", out_re); end
      checks++; if (out_im !== '0) begin errors++; $display("FAIL rst_out_im got=%h exp=0", out_im); end
      low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!in_ready) low++;
      end
      checks++; if (low !== 0) begin errors++; $display("FAIL idle_no_drain ready_low=%0d exp=0", low); end
      checks++; if (q_re.size() !== 0) begin errors++; $display("FAIL idle_no_output got=%0d exp=0", q_re.size()); end
   endtask

   task automatic run_frame_check(input string tag);
      int low;
      clear_q();
      for (int n = 0; n < 2*DEPTH; n++) push(rep_i(n), rep_i(-n));
      in_valid = 1'b0;
      low = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (!in_ready) low++;
      end
      idle(10);
      checks++; if (low !== DEPTH) begin errors++; $display("FAIL %s_drain_cycles got=%0d exp=%0d", tag, low, DEPTH); end
      checks++; if (q_re.size() !== 2*DEPTH) begin errors++; $display("FAIL %s_out_count got=%0d exp=%0d", tag, q_re.size(), 2*DEPTH); end
      for (int i = 0; i < q_re.size() && i < 2*DEPTH; i++) begin
         logic [VO-1:0] er, ei;
         er = (i < DEPTH) ? rep_o(2*i + 16) : rep_o(-16);
         ei = (i < DEPTH) ? rep_o(-(2*i + 16)) : rep_o(16);
         checks++;
         if (q_re[i] !== er || q_im[i] !== ei) begin
            errors++;
            $display("FAIL %s_out[%0d] got re=%h im=%h exp re=%h im=%h", tag, i, q_re[i], q_im[i], er, ei);
         end
      end
   endtask

   task automatic test_single();
      apply_reset();
      run_frame_check("single");
   endtask

   task automatic check_two_frames(input string tag);
      checks++; if (q_re.size() !== 64) begin errors++; $display("FAIL %s_out_count got=%0d exp=64", tag, q_re.size()); end
      for (int i = 0; i < q_re.size() && i < 64; i++) begin
         logic [VO-1:0] er, ei;
         er = rep_o(exp2_re(i));
         ei = rep_o(exp2_im(i));
         checks++;
         if (q_re[i] !== er || q_im[i] !== ei) begin
            errors++;
            $display("FAIL %s_out[%0d] got re=%h im=%h exp re=%h im=%h", tag, i, q_re[i], q_im[i], er, ei);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      ready_waits = 0;
      for (int n = 0; n < 2*DEPTH; n++) push(rep_i(n), rep_i(-n));
      for (int n = 0; n < 2*DEPTH; n++) push(rep_i(2*n), rep_i(n));
      idle(40);
      checks++; if (ready_waits !== 0) begin errors++; $display("FAIL b2b_ready_stalls got=%0d exp=0", ready_waits); end
      checks++;
      if (q_t.size() < 48 || q_t[47] - q_t[0] !== 47) begin
         errors++;
         $display("FAIL b2b_continuous outputs=%0d span=%0d exp_span=47", q_t.size(),
                  (q_t.size() >= 48) ? q_t[47] - q_t[0] : -1);
      end
      check_two_frames("b2b");
   endtask

   task automatic test_stalls();
      int gap, gaps;
      apply_reset();
      gaps = 0;
      for (int k = 0; k < 4*DEPTH; k++) begin
         // no gap at the frame-1 boundary, where idling would start a drain
         gap = (k == 2*DEPTH) ? 0 : int'($urandom_range(0, 2));
         gaps += gap;
         if (gap > 0) idle(gap);
         if (k < 2*DEPTH) push(rep_i(k), rep_i(-k));
         else             push(rep_i(2*(k-2*DEPTH)), rep_i(k-2*DEPTH));
      end
      idle(40);
      checks++; if (gaps == 0) begin errors++; $display("FAIL stall_gaps got=0 exp=nonzero"); end
      check_two_frames("stall");
   endtask

   task automatic test_extremes();
      int ar[ARRAY], br[ARRAY], ai[ARRAY], bi[ARRAY];
      logic [VI-1:0] va_re, va_im, vb_re, vb_im;
      for (int l = 0; l < ARRAY; l++) begin
         ar[l] = l*15 - 120; br[l] = 100 - l*13;
         ai[l] = -l*7;       bi[l] = l*11 - 90;
      end
      ar[0] = -256; br[0] = -256; ai[0] = 255;  bi[0] = -256;
      ar[1] = 255;  br[1] = -256; ai[1] = -256; bi[1] = -256;
      for (int l = 0; l < ARRAY; l++) begin
         va_re[l*DATA +: DATA] = DATA'(ar[l]);
         va_im[l*DATA +: DATA] = DATA'(ai[l]);
         vb_re[l*DATA +: DATA] = DATA'(br[l]);
         vb_im[l*DATA +: DATA] = DATA'(bi[l]);
      end
      apply_reset();
      for (int n = 0; n < DEPTH; n++) push(va_re, va_im);
      for (int n = 0; n < DEPTH; n++) push(vb_re, vb_im);
      idle(30);
      checks++; if (q_re.size() !== 2*DEPTH) begin errors++; $display("FAIL ext_out_count got=%0d exp=%0d", q_re.size(), 2*DEPTH); end
      for (int i = 0; i < q_re.size() && i < 2*DEPTH; i++) begin
         for (int l = 0; l < ARRAY; l++) begin
            logic [W-1:0] er, ei;
            er = (i < DEPTH) ? W'(ar[l] + br[l]) : W'(ar[l] - br[l]);
            ei = (i < DEPTH) ? W'(ai[l] + bi[l]) : W'(ai[l] - bi[l]);
            checks++;
            if (q_re[i][l*W +: W] !== er || q_im[i][l*W +: W] !== ei) begin
               errors++;
               $display("FAIL ext_out[%0d]_lane%0d got re=%h im=%h exp re=%h im=%h", i, l,
                        q_re[i][l*W +: W], q_im[i][l*W +: W], er, ei);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int n = 0; n < 20; n++) push(rep_i(n + 50), rep_i(-n - 50));
      in_valid = 1'b0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_re !== '0) begin errors++; $display("FAIL midrst_outputs got valid=%0b re=%h exp valid=0 re=0", out_valid, out_re); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
      run_frame_check("midrst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stalls();
      test_extremes();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
